// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST engine: FSM state encoding,
// maximal-length LFSR tap masks per supported width, and the zero-seed fix-up.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRIVE = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } bist_state_e;

    // Tap masks: bit (n-1) set for each polynomial exponent n.
    // 8:  x^8+x^6+x^5+x^4+1
    // 16: x^16+x^15+x^13+x^4+1
    // 32: x^32+x^22+x^2+x^1+1
    // 64: x^64+x^63+x^61+x^60+1
    localparam logic [63:0] TAPS_W8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_D008;
    localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

    // An all-zero LFSR state would lock up, so it is replaced by this value.
    localparam logic [63:0] ZERO_SEED_SUB = 64'd1;

    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] taps;
        case (width)
            8:       taps = TAPS_W8;
            16:      taps = TAPS_W16;
            32:      taps = TAPS_W32;
            default: taps = TAPS_W64;
        endcase
        return taps;
    endfunction

    // Truncate a seed to the LFSR width and substitute a non-zero value if needed.
    function automatic logic [63:0] seed_fix(input logic [63:0] seed, input int width);
        logic [63:0] mask;
        logic [63:0] trunc;
        mask  = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        trunc = seed & mask;
        return (trunc == 64'd0) ? ZERO_SEED_SUB : trunc;
    endfunction

endpackage

// File: rtl/adder_bist_engine_lfsr.sv
// Fibonacci LFSR operand generator: reloads its (fixed-up) seed on reset or
// load, and advances one step when step is asserted.
module bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH = 64,
    parameter logic [63:0] SEED  = 64'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAP_MASK  = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_INIT = WIDTH'(seed_fix(SEED, WIDTH));

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] tap_bits;
    logic             feedback;

    // Select the tapped state bits; their parity is the bit shifted in.
    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
        assign tap_bits[gi] = q_reg[gi] & TAP_MASK[gi];
    end

    assign feedback = ^tap_bits;
    assign q_next   = {q_reg[WIDTH-2:0], feedback};
    assign q        = q_reg;

    // State register: seed on reset/load, shift on step, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= SEED_INIT;
        end else if (load) begin
            q_reg <= SEED_INIT;
        end else if (step) begin
            q_reg <= q_next;
        end
    end

endmodule

// File: rtl/adder_bist_engine.sv
// Adder BIST engine: drives LFSR operands into an external adder, checks the
// returned sum against a golden a+b and keeps pass/fail statistics.
// Optional macro ADDER_BIST_FAILCAP_EN adds capture of the first failing
// operands and DUT sum on fail_a_o / fail_b_o / fail_sum_o.
module adder_bist_engine
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH       = 64,
    parameter int          NUM_TESTS   = 10000,
    parameter logic [63:0] SEED_A      = 64'h5,
    parameter logic [63:0] SEED_B      = 64'hA5A5_1,
    parameter int          DUT_LATENCY = 0,
    localparam int         CW          = $clog2(NUM_TESTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] dut_sum_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    pass_count,
    output logic [CW-1:0]    fail_count,
    output logic [CW-1:0]    first_fail_idx
`ifdef ADDER_BIST_FAILCAP_EN
    ,
    output logic [WIDTH-1:0] fail_a_o,
    output logic [WIDTH-1:0] fail_b_o,
    output logic [WIDTH-1:0] fail_sum_o
`endif
);

    localparam int WCW = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;

    bist_state_e      state_reg;
    bist_state_e      state_next;
    logic [WCW-1:0]   wait_cnt_reg;
    logic [CW-1:0]    idx_reg;
    logic [CW-1:0]    pass_count_reg;
    logic [CW-1:0]    fail_count_reg;
    logic [CW-1:0]    first_fail_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] lfsr_a_q;
    logic [WIDTH-1:0] lfsr_b_q;
    logic [WIDTH-1:0] golden_sum;
    logic             sum_match;
    logic             load_fire;
    logic             drive_fire;
    logic             check_fire;

    // Abort suppresses every state action so outputs and counters hold.
    assign load_fire  = (state_reg == LOAD)  && !abort;
    assign drive_fire = (state_reg == DRIVE) && !abort;
    assign check_fire = (state_reg == CHECK) && !abort;

    // Carry-out is discarded: the DUT is only expected to return sum mod 2^WIDTH.
    assign golden_sum = a_reg + b_reg;
    assign sum_match  = (dut_sum_i == golden_sum);

    bist_lfsr #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_fire),
        .step  (drive_fire),
        .q     (lfsr_a_q)
    );

    bist_lfsr #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_fire),
        .step  (drive_fire),
        .q     (lfsr_b_q)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides any other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  state_next = DRIVE;
            DRIVE: begin
                if (DUT_LATENCY == 0) state_next = CHECK;
                else                  state_next = WAIT;
            end
            WAIT:  if (int'(wait_cnt_reg) == DUT_LATENCY - 1) state_next = CHECK;
            CHECK: begin
                if (idx_reg < CW'(NUM_TESTS - 1)) state_next = DRIVE;
                else                              state_next = DONE;
            end
            DONE:  if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // Counts cycles spent waiting for a pipelined DUT to produce its sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == DRIVE) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // Operand registers: capture the LFSR values when a new vector is driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (drive_fire) begin
            a_reg <= lfsr_a_q;
            b_reg <= lfsr_b_q;
        end
    end

    // Vector index and statistics; counters saturate at NUM_TESTS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= '0;
            pass_count_reg <= '0;
            fail_count_reg <= '0;
            first_fail_reg <= '1;
        end else if (load_fire) begin
            idx_reg        <= '0;
            pass_count_reg <= '0;
            fail_count_reg <= '0;
            first_fail_reg <= '1;
        end else if (check_fire) begin
            if (sum_match) begin
                if (pass_count_reg != CW'(NUM_TESTS)) pass_count_reg <= pass_count_reg + 1'b1;
            end else begin
                if (fail_count_reg != CW'(NUM_TESTS)) fail_count_reg <= fail_count_reg + 1'b1;
                if (first_fail_reg == '1) first_fail_reg <= idx_reg;
            end
            if (idx_reg != CW'(NUM_TESTS)) idx_reg <= idx_reg + 1'b1;
        end
    end

`ifdef ADDER_BIST_FAILCAP_EN
    logic [WIDTH-1:0] fail_a_reg;
    logic [WIDTH-1:0] fail_b_reg;
    logic [WIDTH-1:0] fail_sum_reg;

    // Latch operands and DUT sum of the first mismatch in a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a_reg   <= '0;
            fail_b_reg   <= '0;
            fail_sum_reg <= '0;
        end else if (load_fire) begin
            fail_a_reg   <= '0;
            fail_b_reg   <= '0;
            fail_sum_reg <= '0;
        end else if (check_fire && !sum_match && (first_fail_reg == '1)) begin
            fail_a_reg   <= a_reg;
            fail_b_reg   <= b_reg;
            fail_sum_reg <= dut_sum_i;
        end
    end

    assign fail_a_o   = fail_a_reg;
    assign fail_b_o   = fail_b_reg;
    assign fail_sum_o = fail_sum_reg;
`endif

    assign a_o            = a_reg;
    assign b_o            = b_reg;
    assign busy           = (state_reg == LOAD) || (state_reg == DRIVE) ||
                            (state_reg == WAIT) || (state_reg == CHECK);
    assign done           = (state_reg == DONE);
    assign pass           = (state_reg == DONE) && (fail_count_reg == '0);
    assign pass_count     = pass_count_reg;
    assign fail_count     = fail_count_reg;
    assign first_fail_idx = first_fail_reg;

endmodule

// File: tb/tb_adder_bist_engine.sv
// Scoreboard bench for adder_bist_engine: two instances (combinational DUT with
// fault injection, and 2-stage pipelined DUT with a zero A seed), checked
// against an LFSR polynomial model and per-run expected statistics.
module tb_adder_bist_engine;

    localparam int W  = 64;
    localparam int N  = 16;
    localparam int CW = 5;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          fail;
    } vec_t;

    typedef struct {
        int pc;
        int fc;
        int ffi;
        bit pass;
        int lat;
    } run_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [W-1:0] a0, b0, a1, b1, dut_sum0, dut_sum1, p1_reg, p2_reg;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [CW-1:0] pc0, fc0, ffi0, pc1, fc1, ffi1;
    logic [CW-1:0] idx0;
    logic [15:0] mask0 = '0;
    logic [63:0] flip0 = '0;
`ifdef ADDER_BIST_FAILCAP_EN
    logic [W-1:0] fail_a0, fail_b0, fail_sum0, fail_a1, fail_b1, fail_sum1;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_edge0 = 0, start_edge1 = 0;
    logic [63:0] ea0 [N];
    logic [63:0] eb0 [N];
    logic [63:0] ea1 [N];
    logic [63:0] eb1 [N];
    vec_t vq0[$], vq1[$];
    run_t rq0[$], rq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational DUT with per-vector fault injection (vector index = checks done so far).
    assign idx0     = pc0 + fc0;
    assign dut_sum0 = (a0 + b0) ^ (mask0[idx0[3:0]] ? flip0 : 64'd0);

    // Two-stage registered ideal DUT.
    always @(posedge clk) begin
        p1_reg <= a1 + b1;
        p2_reg <= p1_reg;
    end
    assign dut_sum1 = p2_reg;

    adder_bist_engine #(.WIDTH(W), .NUM_TESTS(N), .SEED_A(64'h5), .SEED_B(64'hA5A5_1),
                        .DUT_LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a_o(a0), .b_o(b0), .dut_sum_i(dut_sum0),
        .busy(busy0), .done(done0), .pass(pass0),
        .pass_count(pc0), .fail_count(fc0), .first_fail_idx(ffi0)
`ifdef ADDER_BIST_FAILCAP_EN
        , .fail_a_o(fail_a0), .fail_b_o(fail_b0), .fail_sum_o(fail_sum0)
`endif
    );

    adder_bist_engine #(.WIDTH(W), .NUM_TESTS(N), .SEED_A(64'h0), .SEED_B(64'hA5A5_1),
                        .DUT_LATENCY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a_o(a1), .b_o(b1), .dut_sum_i(dut_sum1),
        .busy(busy1), .done(done1), .pass(pass1),
        .pass_count(pc1), .fail_count(fc1), .first_fail_idx(ffi1)
`ifdef ADDER_BIST_FAILCAP_EN
        , .fail_a_o(fail_a1), .fail_b_o(fail_b1), .fail_sum_o(fail_sum1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference LFSR step from the polynomial x^64+x^63+x^61+x^60+1.
    function automatic logic [63:0] model_step(input logic [63:0] x);
        int taps [4] = '{64, 63, 61, 60};
        logic fb = 1'b0;
        foreach (taps[k]) fb = fb ^ x[taps[k] - 1];
        return {x[62:0], fb};
    endfunction

    // Vector i of a run is the LFSR state after i steps from the seed.
    task automatic gen_vectors(input logic [63:0] sa, input logic [63:0] sb,
                               output logic [63:0] va [N], output logic [63:0] vb [N]);
        logic [63:0] xa, xb;
        xa = (sa == 64'd0) ? 64'd1 : sa;
        xb = (sb == 64'd0) ? 64'd1 : sb;
        for (int i = 0; i < N; i++) begin
            va[i] = xa;
            vb[i] = xb;
            xa = model_step(xa);
            xb = model_step(xb);
        end
    endtask

    // Monitor for instance 0: one vector per counter step, one run result per done rise.
    int   prev_tot0 = 0, prev_fc0 = 0;
    logic done_prev0 = 1'b0;
    always @(negedge clk) begin
        vec_t v;
        run_t r;
        if (!rst_n) begin
            prev_tot0 = 0; prev_fc0 = 0; done_prev0 = 1'b0;
        end else begin
            if (int'(pc0) + int'(fc0) == prev_tot0 + 1) begin
                if (vq0.size() == 0) begin
                    check("u0_vec_unexpected", 64'(vq0.size()), 64'd1);
                end else begin
                    v = vq0.pop_front();
                    check("u0_vec_a", a0, v.a);
                    check("u0_vec_b", b0, v.b);
                    check("u0_vec_fail", 64'(int'(fc0) != prev_fc0), 64'(v.fail));
                    $display("u0 vec %0d a=%h b=%h fault=%0d", prev_tot0, a0, b0, v.fail);
                end
            end
            if (done0 && !done_prev0) begin
                if (rq0.size() == 0) begin
                    check("u0_run_unexpected", 64'(rq0.size()), 64'd1);
                end else begin
                    r = rq0.pop_front();
                    check("u0_pass_count", 64'(pc0), 64'(r.pc));
                    check("u0_fail_count", 64'(fc0), 64'(r.fc));
                    check("u0_first_fail", 64'(ffi0), 64'(r.ffi));
                    check("u0_pass", 64'(pass0), 64'(r.pass));
                    check("u0_latency", 64'(cyc - start_edge0), 64'(r.lat));
                    $display("u0 run done pc=%0d fc=%0d ffi=%0d pass=%0d lat=%0d",
                             pc0, fc0, ffi0, pass0, cyc - start_edge0);
                end
            end
            prev_tot0  = int'(pc0) + int'(fc0);
            prev_fc0   = int'(fc0);
            done_prev0 = done0;
        end
    end

    // Monitor for instance 1 (pipelined DUT).
    int   prev_tot1 = 0;
    logic done_prev1 = 1'b0;
    always @(negedge clk) begin
        vec_t v;
        run_t r;
        if (!rst_n) begin
            prev_tot1 = 0; done_prev1 = 1'b0;
        end else begin
            if (int'(pc1) + int'(fc1) == prev_tot1 + 1) begin
                if (vq1.size() == 0) begin
                    check("u1_vec_unexpected", 64'(vq1.size()), 64'd1);
                end else begin
                    v = vq1.pop_front();
                    check("u1_vec_a", a1, v.a);
                    check("u1_vec_b", b1, v.b);
                    $display("u1 vec %0d a=%h b=%h", prev_tot1, a1, b1);
                end
            end
            if (done1 && !done_prev1) begin
                if (rq1.size() == 0) begin
                    check("u1_run_unexpected", 64'(rq1.size()), 64'd1);
                end else begin
                    r = rq1.pop_front();
                    check("u1_pass_count", 64'(pc1), 64'(r.pc));
                    check("u1_fail_count", 64'(fc1), 64'(r.fc));
                    check("u1_first_fail", 64'(ffi1), 64'(r.ffi));
                    check("u1_pass", 64'(pass1), 64'(r.pass));
                    check("u1_latency", 64'(cyc - start_edge1), 64'(r.lat));
                    $display("u1 run done pc=%0d fc=%0d pass=%0d lat=%0d",
                             pc1, fc1, pass1, cyc - start_edge1);
                end
            end
            prev_tot1  = int'(pc1) + int'(fc1);
            done_prev1 = done1;
        end
    end

    task automatic push_vectors0(input logic [15:0] mask);
        vec_t v;
        for (int i = 0; i < N; i++) begin
            v.a = ea0[i]; v.b = eb0[i]; v.fail = mask[i];
            vq0.push_back(v);
        end
    endtask

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start_edge0 = cyc;
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done0) break;
        end
        check("u0_done_reached", 64'(done0), 64'd1);
    endtask

    // Full run on instance 0 with faults on the vectors selected by mask.
    task automatic run0(input logic [15:0] mask, input logic [63:0] flip);
        run_t r;
        int nf = 0;
        int ff = -1;
        mask0 = mask;
        flip0 = flip;
        push_vectors0(mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                nf++;
                if (ff < 0) ff = i;
            end
        end
        r.pc = N - nf; r.fc = nf; r.ffi = (ff < 0) ? 31 : ff;
        r.pass = (nf == 0); r.lat = 2 * N + 1;
        rq0.push_back(r);
        pulse_start0();
        wait_done0(200);
        @(negedge clk);
`ifdef ADDER_BIST_FAILCAP_EN
        if (ff >= 0) begin
            check("u0_fail_a", fail_a0, ea0[ff]);
            check("u0_fail_b", fail_b0, eb0[ff]);
            check("u0_fail_sum", fail_sum0, (ea0[ff] + eb0[ff]) ^ flip);
        end
`endif
    endtask

    initial begin
        run_t r1;
        vec_t v1;
        logic [63:0] rflip;
        gen_vectors(64'h5, 64'hA5A5_1, ea0, eb0);
        gen_vectors(64'h0, 64'hA5A5_1, ea1, eb1);

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check("rst_a0", a0, 64'd0);
        check("rst_b0", b0, 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_done0", 64'(done0), 64'd0);
        check("rst_pass0", 64'(pass0), 64'd0);
        check("rst_pc0", 64'(pc0), 64'd0);
        check("rst_fc0", 64'(fc0), 64'd0);
        check("rst_ffi0", 64'(ffi0), 64'd31);
        check("rst_a1", a1, 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_ffi1", 64'(ffi1), 64'd31);
`ifdef ADDER_BIST_FAILCAP_EN
        check("rst_fail_a0", fail_a0, 64'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal DUT, all-vector MSB fault, single fault at vector 3.
        run0(16'h0000, 64'd0);
        run0(16'hFFFF, 64'h8000_0000_0000_0000);
        run0(16'h0008, 64'd1);

        // Randomised fault masks and fault patterns.
        for (int t = 0; t < 3; t++) begin
            rflip = {$urandom, $urandom} | 64'd1;
            run0(16'($urandom_range(0, 65535)), rflip);
        end

        // Abort after the 5th check.
        mask0 = '0;
        push_vectors0(16'h0000);
        pulse_start0();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (int'(pc0) + int'(fc0) == 5) break;
        end
        check("abort_reached_5", 64'(pc0), 64'd5);
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_done", 64'(done0), 64'd0);
        check("abort_pc_held", 64'(pc0), 64'd5);
        check("abort_a_held", a0, ea0[4]);
        check("abort_b_held", b0, eb0[4]);
        vq0.delete();
        run0(16'h0000, 64'd0);

        // Asynchronous reset in the middle of a run.
        push_vectors0(16'h0000);
        pulse_start0();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (int'(pc0) + int'(fc0) == 7) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_a0", a0, 64'd0);
        check("midrst_busy0", 64'(busy0), 64'd0);
        check("midrst_done0", 64'(done0), 64'd0);
        check("midrst_pc0", 64'(pc0), 64'd0);
        check("midrst_ffi0", 64'(ffi0), 64'd31);
        vq0.delete();
        rq0.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run0(16'h0000, 64'd0);
        run0(16'h0000, 64'd0);

        // Pipelined DUT with zero A seed: first operand must be the substitute seed.
        for (int i = 0; i < N; i++) begin
            v1.a = ea1[i]; v1.b = eb1[i]; v1.fail = 1'b0;
            vq1.push_back(v1);
        end
        r1.pc = N; r1.fc = 0; r1.ffi = 31; r1.pass = 1'b1; r1.lat = 4 * N + 1;
        rq1.push_back(r1);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start_edge1 = cyc;
        start1 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done1) break;
        end
        check("u1_done_reached", 64'(done1), 64'd1);
        @(negedge clk);

        check("vq0_drained", 64'(vq0.size()), 64'd0);
        check("rq0_drained", 64'(rq0.size()), 64'd0);
        check("vq1_drained", 64'(vq1.size()), 64'd0);
        check("rq1_drained", 64'(rq1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
